apb_gpio_irq: RTL and testbench

Parametrised APB3 GPIO slave, the next generation of the team's APB GPIO block. Adds configurable pin count, two-flop input synchronisers, per-pin edge/level interrupts with W1C status, a registered interrupt line and optional input debounce. Sits on the APB bus as one slave (high address decode external) and drives the LED/key pins plus an interrupt to the CPU.

---
 rtl/apb_gpio_irq.sv | 161 ++++++++++++++++
 tb/tb_apb_gpio_irq.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/apb_gpio_irq.sv
// APB3 GPIO slave: parametrised pin count, two-flop input sync, per-pin edge/level
// interrupts with W1C status and registered oIRQ. Optional input debounce via APB_GPIO_DEBOUNCE_EN.
module apb_gpio_irq #(
  parameter int GPIO_WIDTH = 32,
  parameter int ADDR_LSB_W = 6
) (
  input  logic                  iPCLK,
  input  logic                  iPRESETn,
  input  logic [31:0]           iPADDR,
  input  logic                  iPSEL,
  input  logic                  iPENABLE,
  input  logic                  iPWRITE,
  input  logic [31:0]           iPWDATA,
  output logic                  oPREADY,
  output logic [31:0]           oPRDATA,
  input  logic [GPIO_WIDTH-1:0] GPIO_in,
  output logic [GPIO_WIDTH-1:0] GPIO_out,
  output logic                  oIRQ
);

  typedef logic [GPIO_WIDTH-1:0] pinVec_t;
  typedef logic [ADDR_LSB_W-1:0] regOff_t;

  localparam regOff_t OFF_DATA_RO  = regOff_t'(6'h00);
  localparam regOff_t OFF_DATA     = regOff_t'(6'h04);
  localparam regOff_t OFF_DIRM     = regOff_t'(6'h08);
  localparam regOff_t OFF_OEN      = regOff_t'(6'h0C);
  localparam regOff_t OFF_INT_EN   = regOff_t'(6'h10);
  localparam regOff_t OFF_INT_TYPE = regOff_t'(6'h14);
  localparam regOff_t OFF_INT_POL  = regOff_t'(6'h18);
  localparam regOff_t OFF_INT_ANY  = regOff_t'(6'h1C);
  localparam regOff_t OFF_INT_STAT = regOff_t'(6'h20);
  localparam regOff_t OFF_DB_DIV   = regOff_t'(6'h24);

  pinVec_t data, dirm, oen, intEn, intType, intPol, intAny, intStat;
  pinVec_t sync1, sync2, pinQ, pinD;
  pinVec_t rising, falling, edgeEvt, levelEvt, evt, statClr;
  regOff_t regOff;
  pinVec_t wrBits;
  logic    wrEn;
  logic    unusedBits;

  assign regOff     = iPADDR[ADDR_LSB_W-1:0];
  assign wrBits     = iPWDATA[GPIO_WIDTH-1:0];
  assign wrEn       = iPSEL & iPENABLE & iPWRITE;
  assign oPREADY    = 1'b1;
  assign unusedBits = ^{iPADDR, iPWDATA};

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge iPCLK or negedge iPRESETn) begin
    if (!iPRESETn) begin
      data    <= '0;
      dirm    <= '0;
      oen     <= '0;
      intEn   <= '0;
      intType <= '0;
      intPol  <= '0;
      intAny  <= '0;
    end else if (wrEn) begin
      case (regOff)
        OFF_DATA:     data    <= wrBits;
        OFF_DIRM:     dirm    <= wrBits;
        OFF_OEN:      oen     <= wrBits;
        OFF_INT_EN:   intEn   <= wrBits;
        OFF_INT_TYPE: intType <= wrBits;
        OFF_INT_POL:  intPol  <= wrBits;
        OFF_INT_ANY:  intAny  <= wrBits;
        default: ;
      endcase
    end
  end

  always_ff @(posedge iPCLK or negedge iPRESETn) begin
    if (!iPRESETn) begin
      sync1 <= '0;
      sync2 <= '0;
      pinD  <= '0;
    end else begin
      sync1 <= GPIO_in;
      sync2 <= sync1;
      pinD  <= pinQ;
    end
  end

`ifdef APB_GPIO_DEBOUNCE_EN
  logic [15:0] dbDiv, dbCnt;
  logic        dbTick, dbWr;
  pinVec_t     hist0, hist1, agree;

  assign dbWr   = wrEn && (regOff == OFF_DB_DIV);
  assign dbTick = (dbCnt == dbDiv);

  always_ff @(posedge iPCLK or negedge iPRESETn) begin
    if (!iPRESETn) begin
      dbDiv <= '0;
      dbCnt <= '0;
      hist0 <= '0;
      hist1 <= '0;
    end else begin
      if (dbWr) dbDiv <= iPWDATA[15:0];
      dbCnt <= (dbWr || dbTick) ? 16'd0 : dbCnt + 16'd1;
      if (dbTick) begin
        hist0 <= sync2;
        hist1 <= hist0;
      end
    end
  end

  // The live sync2 level is the third sample; pinD holds the last accepted level.
  assign agree = ~(sync2 ^ hist0) & ~(hist0 ^ hist1);
  assign pinQ  = (agree & sync2) | (~agree & pinD);
`else
  assign pinQ = sync2;
`endif

  assign rising   = pinQ & ~pinD;
  assign falling  = ~pinQ & pinD;
  assign edgeEvt  = (intAny & (rising | falling)) |
                    (~intAny & ((intPol & rising) | (~intPol & falling)));
  assign levelEvt = ~(pinQ ^ intPol);
  assign evt      = ~dirm & ((intType & edgeEvt) | (~intType & levelEvt));
  assign statClr  = (wrEn && (regOff == OFF_INT_STAT)) ? wrBits : '0;

  // Set is OR-ed after the clear so a new event wins over a simultaneous W1C.
  always_ff @(posedge iPCLK or negedge iPRESETn) begin
    if (!iPRESETn) begin
      intStat <= '0;
      oIRQ    <= 1'b0;
    end else begin
      intStat <= (intStat & ~statClr) | evt;
      oIRQ    <= |(intStat & intEn);
    end
  end

  // NOTE: combinational outputs get a default first so no path can infer a latch.
  always_comb begin
    oPRDATA = '0;
    if (iPSEL && !iPWRITE) begin
      case (regOff)
        OFF_DATA_RO:  oPRDATA = 32'((dirm & data & oen) | (~dirm & pinQ));
        OFF_DATA:     oPRDATA = 32'(data);
        OFF_DIRM:     oPRDATA = 32'(dirm);
        OFF_OEN:      oPRDATA = 32'(oen);
        OFF_INT_EN:   oPRDATA = 32'(intEn);
        OFF_INT_TYPE: oPRDATA = 32'(intType);
        OFF_INT_POL:  oPRDATA = 32'(intPol);
        OFF_INT_ANY:  oPRDATA = 32'(intAny);
        OFF_INT_STAT: oPRDATA = 32'(intStat);
`ifdef APB_GPIO_DEBOUNCE_EN
        OFF_DB_DIV:   oPRDATA = 32'(dbDiv);
`endif
        default:      oPRDATA = '0;
      endcase
    end
  end

  for (genvar i = 0; i < GPIO_WIDTH; i++) begin : gPinDrive
    assign GPIO_out[i] = (dirm[i] & oen[i]) ? data[i] : 1'bz;
  end

endmodule

// File: tb/tb_apb_gpio_irq.sv
// Directed self-checking bench for apb_gpio_irq on an 8-pin build; debounce section
// is compiled in only when APB_GPIO_DEBOUNCE_EN is defined.
module tb_apb_gpio_irq;

  localparam int GW = 8;
`ifdef APB_GPIO_DEBOUNCE_EN
  localparam int FILT_LAT = 2;
`else
  localparam int FILT_LAT = 0;
`endif

  localparam logic [31:0] A_DATA_RO  = 32'h00;
  localparam logic [31:0] A_DATA     = 32'h04;
  localparam logic [31:0] A_DIRM     = 32'h08;
  localparam logic [31:0] A_OEN      = 32'h0C;
  localparam logic [31:0] A_INT_EN   = 32'h10;
  localparam logic [31:0] A_INT_TYPE = 32'h14;
  localparam logic [31:0] A_INT_POL  = 32'h18;
  localparam logic [31:0] A_INT_ANY  = 32'h1C;
  localparam logic [31:0] A_INT_STAT = 32'h20;
  localparam logic [31:0] A_UNMAPPED = 32'h28;

  logic          clk = 1'b0;
  logic          rstn;
  logic [31:0]   paddr, pwdata, prdata;
  logic          psel, penable, pwrite, pready, irq;
  logic [GW-1:0] gpioIn;
  wire  [GW-1:0] gpioOut;
  logic [31:0]   rd;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  apb_gpio_irq #(.GPIO_WIDTH(GW), .ADDR_LSB_W(6)) dut (
    .iPCLK(clk), .iPRESETn(rstn), .iPADDR(paddr), .iPSEL(psel), .iPENABLE(penable),
    .iPWRITE(pwrite), .iPWDATA(pwdata), .oPREADY(pready), .oPRDATA(prdata),
    .GPIO_in(gpioIn), .GPIO_out(gpioOut), .oIRQ(irq)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Full setup+access write; returns just after the negedge following the commit edge.
  task automatic apbWrite(input logic [31:0] addr, input logic [31:0] wdata);
    @(negedge clk);
    psel = 1'b1; pwrite = 1'b1; penable = 1'b0; paddr = addr; pwdata = wdata;
    @(negedge clk);
    penable = 1'b1;
    @(negedge clk);
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  // Read data is combinational, so sample 1 time unit into the current half cycle.
  task automatic apbRead(input logic [31:0] addr, output logic [31:0] d);
    psel = 1'b1; pwrite = 1'b0; paddr = addr;
    #1 d = prdata;
    psel = 1'b0;
  endtask

  task automatic readCheck(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    logic [31:0] d;
    apbRead(addr, d);
    check(tag, d, exp);
  endtask

  initial begin
    rstn = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0; gpioIn = '0;
    repeat (3) @(negedge clk);
    check("reset_irq", 32'(irq), 32'h0);
    check("reset_prdata", prdata, 32'h0);
    check("pready", 32'(pready), 32'h1);
    rstn = 1'b1;
    readCheck("reset_stat", A_INT_STAT, 32'h0);
    readCheck("reset_data", A_DATA, 32'h0);
    readCheck("reset_dirm", A_DIRM, 32'h0);
    readCheck("reset_inten", A_INT_EN, 32'h0);

    // Output drive on upper nibble
    apbWrite(A_DIRM, 32'hF0);
    apbWrite(A_OEN, 32'hF0);
    apbWrite(A_DATA, 32'hA5);
    check("gpio_out_hi", 32'(gpioOut[7:4]), 32'hA);
    readCheck("data_ro_out", A_DATA_RO, 32'hA0);
    readCheck("dirm_rb", A_DIRM, 32'hF0);

    // Rising-edge interrupt timing on pin 0
    apbWrite(A_INT_TYPE, 32'hFF);
    apbWrite(A_INT_POL, 32'hFF);
    apbWrite(A_INT_STAT, 32'hFF);
    apbWrite(A_INT_EN, 32'h01);
    readCheck("stat_clean", A_INT_STAT, 32'h0);
    check("irq_clean", 32'(irq), 32'h0);
    @(negedge clk); gpioIn[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    readCheck("rise_stat_n", A_INT_STAT, 32'h0);
    repeat (1 + FILT_LAT) @(negedge clk);
    readCheck("rise_stat_n1", A_INT_STAT, 32'h0);
    @(negedge clk);
    readCheck("rise_stat_n2", A_INT_STAT, 32'h1);
    check("rise_irq_n2", 32'(irq), 32'h0);
    @(negedge clk);
    check("rise_irq_n3", 32'(irq), 32'h1);
    apbWrite(A_INT_STAT, 32'h01);
    readCheck("w1c_stat", A_INT_STAT, 32'h0);
    check("w1c_irq_m", 32'(irq), 32'h1);
    @(negedge clk);
    check("w1c_irq_m1", 32'(irq), 32'h0);

    // Level-low on pin 2 with simultaneous clear
    apbWrite(A_INT_EN, 32'h04);
    apbWrite(A_INT_POL, 32'hFB);
    apbWrite(A_INT_TYPE, 32'hFB);
    repeat (3) @(negedge clk);
    readCheck("level_stat", A_INT_STAT, 32'h04);
    check("level_irq", 32'(irq), 32'h1);
    apbWrite(A_INT_STAT, 32'h04);
    readCheck("level_set_wins", A_INT_STAT, 32'h04);
    @(negedge clk);
    check("level_irq_held", 32'(irq), 32'h1);
    apbWrite(A_INT_EN, 32'h00);
    check("mask_irq_m", 32'(irq), 32'h1);
    @(negedge clk);
    check("mask_irq_m1", 32'(irq), 32'h0);
    readCheck("mask_stat_kept", A_INT_STAT, 32'h04);
    apbWrite(A_INT_TYPE, 32'hFF);
    apbWrite(A_INT_POL, 32'hFF);
    apbWrite(A_INT_STAT, 32'hFF);
    readCheck("restore_stat", A_INT_STAT, 32'h0);

    // Any-edge on pin 3
    apbWrite(A_INT_ANY, 32'h08);
    @(negedge clk); gpioIn[3] = 1'b1;
    repeat (6) @(negedge clk);
    readCheck("any_rise", A_INT_STAT, 32'h08);
    apbWrite(A_INT_STAT, 32'h08);
    readCheck("any_clr", A_INT_STAT, 32'h0);
    @(negedge clk); gpioIn[3] = 1'b0;
    repeat (6) @(negedge clk);
    readCheck("any_fall", A_INT_STAT, 32'h08);
    apbWrite(A_DATA, 32'hFF00_0000);
    readCheck("data_hi_ignored", A_DATA, 32'h0);
    apbWrite(A_UNMAPPED, 32'hFFFF_FFFF);
    readCheck("unmapped", A_UNMAPPED, 32'h0);
    apbWrite(A_DATA_RO, 32'hFF);
    readCheck("data_ro_pins", A_DATA_RO, 32'h01);

`ifdef APB_GPIO_DEBOUNCE_EN
    apbWrite(32'h24, 32'h3);
    readCheck("dbdiv_rb", 32'h24, 32'h3);
    apbWrite(A_INT_STAT, 32'h02);
    @(negedge clk); gpioIn[1] = 1'b1;
    @(negedge clk); gpioIn[1] = 1'b0;
    repeat (14) @(negedge clk);
    apbRead(A_DATA_RO, rd);
    check("db_glitch_pin", 32'(rd[1]), 32'h0);
    apbRead(A_INT_STAT, rd);
    check("db_glitch_stat", 32'(rd[1]), 32'h0);
    @(negedge clk); gpioIn[1] = 1'b1;
    repeat (20) @(negedge clk);
    apbRead(A_DATA_RO, rd);
    check("db_stable_pin", 32'(rd[1]), 32'h1);
    apbRead(A_INT_STAT, rd);
    check("db_stable_stat", 32'(rd[1]), 32'h1);
`endif

    // Reset asserted in the middle of an access phase
    apbWrite(A_DATA, 32'hA5);
    apbWrite(A_INT_EN, 32'h08);
    @(negedge clk);
    check("pre_reset_irq", 32'(irq), 32'h1);
    check("pre_reset_out", 32'(gpioOut[7:4]), 32'hA);
    psel = 1'b1; pwrite = 1'b1; paddr = A_DIRM; pwdata = 32'h0F;
    @(negedge clk);
    penable = 1'b1;
    #2 rstn = 1'b0;
    #1 check("midrst_irq", 32'(irq), 32'h0);
    check("midrst_prdata", prdata, 32'h0);
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    readCheck("post_rst_data", A_DATA, 32'h0);
    readCheck("post_rst_dirm", A_DIRM, 32'h0);
    readCheck("post_rst_inten", A_INT_EN, 32'h0);
    readCheck("post_rst_stat", A_INT_STAT, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
